// File: rtl/tlul_pkg.sv
// TL-UL D-channel types, integrity widths and integrity helpers.
package tlul_pkg;

    localparam int unsigned D2HRspIntgWidth = 7;
    localparam int unsigned DataIntgWidth   = 7;
    localparam int unsigned D2HRspMaxWidth  = 57;
    localparam int unsigned DataMaxWidth    = 32;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [D2HRspIntgWidth-1:0] rsp_intg;
        logic [DataIntgWidth-1:0]   data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic                    d_valid;
        logic [2:0]              d_opcode;
        logic [2:0]              d_param;
        logic [1:0]              d_size;
        logic [7:0]              d_source;
        logic                    d_sink;
        logic [DataMaxWidth-1:0] d_data;
        tl_d_user_t              d_user;
        logic                    d_error;
        logic                    a_ready;
    } tl_d2h_t;

    function automatic logic [D2HRspMaxWidth-1:0] extract_d2h_rsp_intg(
        input tl_d2h_t tl
    );
        logic unused_tl;
        unused_tl = ^tl;
        return D2HRspMaxWidth'({tl.d_opcode, tl.d_size, tl.d_error});
    endfunction

    // Inverted SECDED check bits, matching the inv_64_57 decoder
    function automatic logic [6:0] rsp_intg_gen(input logic [56:0] p);
        logic [6:0] c;
        c[0] = ^(p & 57'h103FFF800007FFF);
        c[1] = ^(p & 57'h17C1FF801FF801F);
        c[2] = ^(p & 57'h1BDE1F87E0781E1);
        c[3] = ^(p & 57'h1DEEE3B8E388E22);
        c[4] = ^(p & 57'h1EF76CDB2C93244);
        c[5] = ^(p & 57'h1F7BB56D5525488);
        c[6] = ^(p & 57'h1FBDDA769A46910);
        return c ^ 7'h2A;
    endfunction

    function automatic logic [6:0] data_intg_gen(input logic [31:0] d);
        logic [6:0] c;
        c[0] = ^(d & 32'h2606BD25);
        c[1] = ^(d & 32'hDEBA8050);
        c[2] = ^(d & 32'h413D89AA);
        c[3] = ^(d & 32'h31234ED1);
        c[4] = ^(d & 32'hC2C1323B);
        c[5] = ^(d & 32'h2DCC624C);
        c[6] = ^(d & 32'h98505586);
        return c ^ 7'h2A;
    endfunction

endpackage

// File: rtl/prim_secded_inv_39_32_dec.sv
// Inverted SECDED(39,32) error detector over {check, data}.
module prim_secded_inv_39_32_dec (
    input  logic [38:0] data_i,
    output logic [1:0]  err_o
);
    logic [38:0] cw;
    logic [6:0]  syn;

    assign cw = data_i ^ 39'h2A00000000;

    assign syn[0] = ^(cw & 39'h012606BD25);
    assign syn[1] = ^(cw & 39'h02DEBA8050);
    assign syn[2] = ^(cw & 39'h04413D89AA);
    assign syn[3] = ^(cw & 39'h0831234ED1);
    assign syn[4] = ^(cw & 39'h10C2C1323B);
    assign syn[5] = ^(cw & 39'h202DCC624C);
    assign syn[6] = ^(cw & 39'h4098505586);

    assign err_o[0] = ^syn;
    assign err_o[1] = ~(^syn) & (|syn);
endmodule

// File: rtl/prim_secded_inv_64_57_dec.sv
// Inverted SECDED(64,57) error detector over {check, payload}.
module prim_secded_inv_64_57_dec (
    input  logic [63:0] data_i,
    output logic [1:0]  err_o
);
    logic [63:0] cw;
    logic [6:0]  syn;

    assign cw = data_i ^ 64'h5400000000000000;

    assign syn[0] = ^(cw & 64'h0303FFF800007FFF);
    assign syn[1] = ^(cw & 64'h057C1FF801FF801F);
    assign syn[2] = ^(cw & 64'h09BDE1F87E0781E1);
    assign syn[3] = ^(cw & 64'h11DEEE3B8E388E22);
    assign syn[4] = ^(cw & 64'h21EF76CDB2C93244);
    assign syn[5] = ^(cw & 64'h41F7BB56D5525488);
    assign syn[6] = ^(cw & 64'h81FBDDA769A46910);

    // odd syndrome weight: single-bit error; even non-zero: double
    assign err_o[0] = ^syn;
    assign err_o[1] = ~(^syn) & (|syn);
endmodule

// File: rtl/tlul_rsp_intg_chk_core.sv
// Combinational response and data integrity check of one D-channel beat.
module tlul_rsp_intg_chk_core
    import tlul_pkg::*;
#(
    parameter logic CheckData = 1'b1
) (
    input  tl_d2h_t tl_i,
    output logic    rsp_err,
    output logic    data_err
);
    logic [D2HRspMaxWidth-1:0] payload;
    logic [1:0]                rsp_e;
    logic [1:0]                data_e;

    assign payload = extract_d2h_rsp_intg(tl_i);

    prim_secded_inv_64_57_dec u_rsp_dec (
        .data_i ({tl_i.d_user.rsp_intg, payload}),
        .err_o  (rsp_e)
    );

    prim_secded_inv_39_32_dec u_data_dec (
        .data_i ({tl_i.d_user.data_intg, tl_i.d_data}),
        .err_o  (data_e)
    );

    assign rsp_err  = |rsp_e;
    assign data_err = (|data_e) & CheckData;
endmodule

// File: rtl/tlul_rsp_intg_chk_buf.sv
// D-channel integrity checker with a 2-entry registered output buffer.
// Define TLUL_RSP_INTG_CHK_FAILCLOSED_EN to poison failing/later beats.
module tlul_rsp_intg_chk_buf
    import tlul_pkg::*;
#(
    parameter logic        CheckData = 1'b1,
    parameter int unsigned ErrCntW   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tl_d2h_t            tl_i,
    output logic               d_ready_o,
    output tl_d2h_t            tl_o,
    input  logic               d_ready_i,
    output logic               intg_err_pulse_o,
    output logic               intg_err_o,
    output logic [ErrCntW-1:0] err_cnt_o
);
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        sink;
        logic [31:0] data;
        tl_d_user_t  user;
        logic        error;
        logic        err;
        logic        kill;
    } entry_t;

    logic       rsp_err;
    logic       data_err;
    logic       err_in;
    logic       push;
    logic       pop;
    logic       hit;
    logic [1:0] count_q;
    logic       wr_ptr_q;
    logic       rd_ptr;
    entry_t     mem_q [2];
    entry_t     wr_entry;
    entry_t     head;

    tlul_rsp_intg_chk_core #(
        .CheckData (CheckData)
    ) u_core (
        .tl_i     (tl_i),
        .rsp_err  (rsp_err),
        .data_err (data_err)
    );

    assign err_in    = rsp_err | data_err;
    assign d_ready_o = (count_q != 2'd2);
    assign push      = tl_i.d_valid & d_ready_o;
    assign pop       = (count_q != 2'd0) & d_ready_i;
    assign hit       = push & err_in;
    // with one entry the head sits behind the write slot
    assign rd_ptr    = wr_ptr_q ^ (count_q == 2'd1);
    assign head      = mem_q[rd_ptr];

    always_comb begin
        wr_entry        = '0;
        wr_entry.opcode = tl_i.d_opcode;
        wr_entry.param  = tl_i.d_param;
        wr_entry.size   = tl_i.d_size;
        wr_entry.source = tl_i.d_source;
        wr_entry.sink   = tl_i.d_sink;
        wr_entry.data   = tl_i.d_data;
        wr_entry.user   = tl_i.d_user;
        wr_entry.error  = tl_i.d_error;
        wr_entry.err    = err_in;
`ifdef TLUL_RSP_INTG_CHK_FAILCLOSED_EN
        wr_entry.kill   = intg_err_o;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intg_err_pulse_o <= 1'b0;
            intg_err_o       <= 1'b0;
            err_cnt_o        <= '0;
        end else begin
            intg_err_pulse_o <= hit;
            if (hit) begin
                intg_err_o <= 1'b1;
            end
            if (hit && (err_cnt_o != '1)) begin
                err_cnt_o <= err_cnt_o + ErrCntW'(1);
            end
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = (count_q != 2'd0);
        tl_o.d_opcode = head.opcode;
        tl_o.d_param  = head.param;
        tl_o.d_size   = head.size;
        tl_o.d_source = head.source;
        tl_o.d_sink   = head.sink;
        tl_o.d_data   = head.data;
        tl_o.d_user   = head.user;
        tl_o.d_error  = head.error;
        tl_o.a_ready  = tl_i.a_ready;
`ifdef TLUL_RSP_INTG_CHK_FAILCLOSED_EN
        if (head.err | head.kill) begin
            tl_o.d_error = 1'b1;
        end
        if (head.kill) begin
            tl_o.d_data = '1;
        end
        // re-sign so the host sees self-consistent integrity
        tl_o.d_user.rsp_intg  = rsp_intg_gen(extract_d2h_rsp_intg(tl_o));
        tl_o.d_user.data_intg = data_intg_gen(tl_o.d_data);
`endif
    end

`ifndef TLUL_RSP_INTG_CHK_FAILCLOSED_EN
    logic unused_head;
    assign unused_head = ^{head.err, head.kill};
`endif

endmodule

// File: tb/tb_tlul_rsp_intg_chk_buf.sv
// Scoreboard bench for tlul_rsp_intg_chk_buf (default and CheckData=0).
module tb_tlul_rsp_intg_chk_buf;
    import tlul_pkg::*;

    localparam logic [31:0] DM [7] = '{
        32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
        32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    localparam logic [56:0] RM [7] = '{
        57'h103FFF800007FFF, 57'h17C1FF801FF801F, 57'h1BDE1F87E0781E1,
        57'h1DEEE3B8E388E22, 57'h1EF76CDB2C93244, 57'h1F7BB56D5525488,
        57'h1FBDDA769A46910};

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       d_ready_i = 1'b1;
    tl_d2h_t    tl_i = '0;
    tl_d2h_t    tl_o;
    tl_d2h_t    tl_o_nd;
    logic       d_ready_o, d_ready_o_nd;
    logic       pulse, sticky, pulse_nd, sticky_nd;
    logic [7:0] cnt, cnt_nd;

    int      vectors = 0;
    int      miscompares = 0;
    tl_d2h_t q[$];
    logic    chk_en = 1'b0;
    logic    exp_pulse = 1'b0, exp_sticky = 1'b0;
    logic    exp_pulse_nd = 1'b0, exp_sticky_nd = 1'b0;
    logic [7:0] exp_cnt = 8'd0, exp_cnt_nd = 8'd0;
    logic    bg_done;

    always #5 clk = ~clk;

    tlul_rsp_intg_chk_buf #(.CheckData(1'b1), .ErrCntW(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i),
        .d_ready_o(d_ready_o), .tl_o(tl_o), .d_ready_i(d_ready_i),
        .intg_err_pulse_o(pulse), .intg_err_o(sticky),
        .err_cnt_o(cnt));

    tlul_rsp_intg_chk_buf #(.CheckData(1'b0), .ErrCntW(8)) dut_nd (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i),
        .d_ready_o(d_ready_o_nd), .tl_o(tl_o_nd), .d_ready_i(d_ready_i),
        .intg_err_pulse_o(pulse_nd), .intg_err_o(sticky_nd),
        .err_cnt_o(cnt_nd));

    function automatic logic [6:0] data_enc(input logic [31:0] d);
        logic [6:0] p = 7'h0;
        for (int k = 0; k < 7; k++)
            for (int i = 0; i < 32; i++)
                if (d[i] && DM[k][i]) p[k] = ~p[k];
        return p ^ 7'h2A;
    endfunction

    function automatic logic [6:0] rsp_enc(input logic [56:0] v);
        logic [6:0] p = 7'h0;
        for (int k = 0; k < 7; k++)
            for (int i = 0; i < 57; i++)
                if (v[i] && RM[k][i]) p[k] = ~p[k];
        return p ^ 7'h2A;
    endfunction

    function automatic tl_d2h_t mk(input logic [2:0] op,
        input logic [1:0] sz, input logic [7:0] src,
        input logic [31:0] data, input logic derr,
        input bit br, input bit bd);
        tl_d2h_t b = '0;
        b.d_valid  = 1'b1;
        b.d_opcode = op;
        b.d_param  = src[2:0];
        b.d_size   = sz;
        b.d_source = src;
        b.d_sink   = src[0];
        b.d_data   = data;
        b.d_error  = derr;
        b.d_user.rsp_intg  = rsp_enc(57'({op, sz, derr}));
        b.d_user.data_intg = data_enc(data);
        if (br) b.d_user.rsp_intg[6] = ~b.d_user.rsp_intg[6];
        if (bd) b.d_data[0] = ~b.d_data[0];
        b.a_ready  = 1'b1;
        return b;
    endfunction

    function automatic tl_d2h_t strip(input tl_d2h_t b);
        tl_d2h_t r = b;
        r.a_ready = 1'b0;
        return r;
    endfunction

`ifdef TLUL_RSP_INTG_CHK_FAILCLOSED_EN
    function automatic tl_d2h_t fc_expect(input tl_d2h_t b,
        input bit bad, input logic stk);
        tl_d2h_t e = b;
        if (bad || stk) e.d_error = 1'b1;
        if (stk) e.d_data = 32'hFFFF_FFFF;
        e.d_user.rsp_intg  = rsp_enc(57'({e.d_opcode, e.d_size, e.d_error}));
        e.d_user.data_intg = data_enc(e.d_data);
        return e;
    endfunction
`endif

    task automatic check(input string name, input logic [65:0] act,
                         input logic [65:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic garbage();
        tl_d2h_t g;
        g = tl_d2h_t'({$urandom, $urandom, $urandom});
        g.d_valid = 1'b0;
        tl_i = g;
    endtask

    // call with time at posedge+1
    task automatic send(input tl_d2h_t b, input bit br, input bit bd);
        bit      ok = 1'b0;
        tl_d2h_t e;
        tl_i = b;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = d_ready_o;
            @(posedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 66'd0, 66'd1);
        end else begin
`ifdef TLUL_RSP_INTG_CHK_FAILCLOSED_EN
            e = fc_expect(b, br | bd, exp_sticky);
`else
            e = b;
`endif
            q.push_back(strip(e));
            if (br || bd) begin
                exp_pulse  = 1'b1;
                exp_sticky = 1'b1;
                if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            end
            if (br) begin
                exp_pulse_nd  = 1'b1;
                exp_sticky_nd = 1'b1;
                if (exp_cnt_nd != 8'hFF) exp_cnt_nd = exp_cnt_nd + 8'd1;
            end
        end
        #1;
        garbage();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            garbage();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush_model();
        q.delete();
        exp_pulse = 1'b0;    exp_sticky = 1'b0;    exp_cnt = 8'd0;
        exp_pulse_nd = 1'b0; exp_sticky_nd = 1'b0; exp_cnt_nd = 8'd0;
    endtask

    always @(negedge clk) begin
        if (rst_ni && chk_en) begin
            check("pulse", 66'(pulse), 66'(exp_pulse));
            check("sticky", 66'(sticky), 66'(exp_sticky));
            check("err_cnt", 66'(cnt), 66'(exp_cnt));
            check("pulse_nd", 66'(pulse_nd), 66'(exp_pulse_nd));
            check("sticky_nd", 66'(sticky_nd), 66'(exp_sticky_nd));
            check("err_cnt_nd", 66'(cnt_nd), 66'(exp_cnt_nd));
            exp_pulse    = 1'b0;
            exp_pulse_nd = 1'b0;
            if (tl_o.d_valid && d_ready_i) begin
                if (q.size() == 0)
                    check("unexpected_beat", 66'(strip(tl_o)), 66'd0);
                else
                    check("beat", 66'(strip(tl_o)), 66'(q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] c0, n0;
        tl_d2h_t b1, b2, b3;

        repeat (3) @(posedge clk);
        check("rst_valid", 66'(tl_o.d_valid), 66'd0);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        check("rst_valid_out", 66'(tl_o.d_valid), 66'd0);
        check("rst_ready", 66'(d_ready_o), 66'd1);
        check("rst_fields", 66'({tl_o.d_opcode, tl_o.d_param,
              tl_o.d_size, tl_o.d_source, tl_o.d_sink,
              tl_o.d_data, tl_o.d_error}), 66'd0);
        check("rst_cnt", 66'(cnt), 66'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        tl_i.a_ready = 1'b1;
        #1 check("a_ready_1", 66'(tl_o.a_ready), 66'd1);
        tl_i.a_ready = 1'b0;
        #1 check("a_ready_0", 66'(tl_o.a_ready), 66'd0);
        @(posedge clk);
        #1;

        send(mk(AccessAckData, 2'd2, 8'h11, 32'h1234_5678, 1'b0, 0, 0), 0, 0);
        check("latency_valid", 66'(tl_o.d_valid), 66'd1);
        check("latency_data", 66'(tl_o.d_data), 66'h1234_5678);
        idle(2);
        send(mk(AccessAck, 2'd0, 8'hA5, 32'h0, 1'b0, 0, 0), 0, 0);
        send(mk(AccessAckData, 2'd1, 8'h3C, 32'hDEAD_BEEF, 1'b1, 0, 0), 0, 0);
        send(mk(AccessAckData, 2'd2, 8'hFF, 32'hFFFF_FFFF, 1'b0, 0, 0), 0, 0);
        idle(3);
        check("clean_sticky", 66'(sticky), 66'd0);

        send(mk(AccessAckData, 2'd2, 8'h22, 32'hCAFE_0001, 1'b0, 0, 1), 0, 1);
        idle(3);
        check("data_err_sticky", 66'(sticky), 66'd1);
        check("data_err_cnt", 66'(cnt), 66'd1);

        c0 = cnt;
        n0 = cnt_nd;
        send(mk(AccessAck, 2'd2, 8'h33, 32'h0, 1'b0, 1, 0), 1, 0);
        send(mk(AccessAckData, 2'd2, 8'h34, 32'h5555_AAAA, 1'b0, 0, 1), 0, 1);
        idle(3);
        check("nd_one_err", 66'(cnt_nd - n0), 66'd1);
        check("main_two_err", 66'(cnt - c0), 66'd2);

        d_ready_i = 1'b0;
        b1 = mk(AccessAckData, 2'd2, 8'h41, 32'h1111_1111, 1'b0, 0, 0);
        b2 = mk(AccessAckData, 2'd2, 8'h42, 32'h2222_2222, 1'b0, 0, 0);
        b3 = mk(AccessAckData, 2'd2, 8'h43, 32'h3333_3333, 1'b0, 0, 0);
        send(b1, 0, 0);
        send(b2, 0, 0);
        check("full_ready", 66'(d_ready_o), 66'd0);
        bg_done = 1'b0;
        fork
            begin
                send(b3, 0, 0);
                bg_done = 1'b1;
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("stall_ready", 66'(d_ready_o), 66'd0);
        check("stall_head", 66'(tl_o.d_source), 66'h41);
        d_ready_i = 1'b1;
        for (int k = 0; k < 40 && !bg_done; k++) @(posedge clk);
        #1;
        check("bg_send_done", 66'(bg_done), 66'd1);
        idle(4);

        d_ready_i = 1'b0;
        send(mk(AccessAckData, 2'd2, 8'h51, 32'h5151_5151, 1'b0, 0, 0), 0, 0);
        send(mk(AccessAckData, 2'd2, 8'h52, 32'h5252_5252, 1'b0, 0, 0), 0, 0);
        check("pre_rst_valid", 66'(tl_o.d_valid), 66'd1);
        #2 rst_ni = 1'b0;
        flush_model();
        #1;
        check("async_rst_valid", 66'(tl_o.d_valid), 66'd0);
        check("async_rst_ready", 66'(d_ready_o), 66'd1);
        @(posedge clk);
        #2 rst_ni = 1'b1;
        d_ready_i = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 66'(d_ready_o), 66'd1);
        check("post_rst_sticky", 66'(sticky), 66'd0);
        check("post_rst_cnt", 66'(cnt), 66'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++)
            send(mk(AccessAckData, 2'(i), 8'(i), 32'(i * 7), 1'b0, 1, 0),
                 1, 0);
        idle(3);
        check("sat_cnt", 66'(cnt), 66'hFF);
        check("sat_cnt_nd", 66'(cnt_nd), 66'hFF);

        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
        check("drain", 66'(q.size()), 66'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tlul_rsp_intg_chk_buf.md
Name: tlul_rsp_intg_chk_buf

Overview:
- Host-side counterpart of the device-side response integrity generator. Sits on the TL-UL D channel between a device (or fabric) and a host port.
- Recomputes and checks the response integrity (`rsp_intg`) and data integrity (`data_intg`) carried in `d_user` on every accepted beat. Forwards each beat through a 2-entry registered buffer.
- Reports integrity errors as a single-cycle pulse, a sticky flag and a saturating count.

Parameters:
- `CheckData`, 1'b1: 1 = check `data_intg` on every beat; 0 = data check disabled, its error term is 0.
- `ErrCntW`, 8: width of the saturating error counter.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `tl_i`  in  66  `tlul_pkg::tl_d2h_t` from the device (`d_valid`, `d_opcode[3]`, `d_param[3]`, `d_size[2]`, `d_source[8]`, `d_sink[1]`, `d_data[32]`, `d_user{rsp_intg[7], data_intg[7]}`, `d_error`, `a_ready`)
- `d_ready_o`  out  1  D-channel ready back to the device
- `tl_o`  out  66  `tlul_pkg::tl_d2h_t` toward the host
- `d_ready_i`  in  1  D-channel ready from the host
- `intg_err_pulse_o`  out  1  one-cycle pulse for each accepted beat that fails a check
- `intg_err_o`  out  1  sticky error flag, cleared only by reset
- `err_cnt_o`  out  `ErrCntW`  saturating count of failing beats

Behaviour:
- Clock and reset:
  - Interface: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
  - All state is cleared on reset assertion regardless of the clock.
- Reset values:
  - `tl_o.d_valid`=0 and all other registered `tl_o` D fields = 0.
  - `d_ready_o`=1.
  - `intg_err_pulse_o`=0, `intg_err_o`=0, `err_cnt_o`=0.
- A-channel passthrough: `tl_o.a_ready` = `tl_i.a_ready`, combinational and unregistered.
- Accept: a beat is accepted when `tl_i.d_valid` && `d_ready_o` at the rising edge.
- Buffer:
  - 2-entry FIFO of {D fields, `err` bit}.
  - `d_ready_o` = !full. It is a registered state decode with no combinational path from `d_ready_i`.
  - `tl_o.d_valid` = !empty; `tl_o` D fields come from the head entry.
  - Pop when `tl_o.d_valid` && `d_ready_i`.
- Latency: a beat accepted in cycle N is visible on `tl_o` in cycle N+1 if the buffer was empty. Sustained throughput is 1 beat/cycle with `d_ready_i`=1.
- Simultaneous push and pop:
  - With 1 entry: occupancy stays 1 and the head advances.
  - With 2 entries: no push is possible because `d_ready_o`=0. A pop frees a slot and `d_ready_o`=1 next cycle.
  - Pop on empty and push on full are impossible by construction.
- Ordering: FIFO order is preserved; beats are never dropped, duplicated or reordered.
- Response check:
  - Payload = 57-bit zero-extension of {`d_opcode`, `d_size`, `d_error`}, with `d_opcode` in the MSBs and `d_error` as bit 0.
  - Decode {`rsp_intg`, payload} with `prim_secded_inv_64_57_dec`.
  - `rsp_err` = |syndrome-derived error[1:0]|; single-bit errors count as errors.
- Data check:
  - Decode {`data_intg`, `d_data`} with `prim_secded_inv_39_32_dec`.
  - `data_err` = |error[1:0]| & `CheckData`.
- Error reporting:
  - `err` = `rsp_err` | `data_err`, evaluated on the input beat and stored with the entry.
  - `intg_err_pulse_o` is registered and asserted in cycle N+1 for a failing beat accepted in cycle N.
  - `intg_err_o` is set on the first pulse.
  - `err_cnt_o` increments per failing beat, saturates at all-ones and never wraps.
- Checks are evaluated only on accepted beats. Garbage on `tl_i` while `d_valid`=0 has no effect.
- Reset mid-operation: buffered beats are discarded and outputs return to reset values. A host still waiting on them must itself be in reset.

Optional Feature:
- Macro: `TLUL_RSP_INTG_CHK_FAILCLOSED_EN`.
- Defined:
  - A buffered entry with `err`=1 is emitted with `d_error` forced to 1.
  - Once `intg_err_o`=1, every later-accepted beat is also emitted with `d_error`=1 and `d_data`=32'hFFFF_FFFF, until reset.
  - `d_user` is regenerated with `tlul_rsp_intg_gen` logic on the emitted fields, so the host sees consistent integrity.
- Undefined: beats are forwarded bit-exact including `d_user`; errors are only reported on the three error outputs.

Decomposition:
- `tlul_pkg` holds `tl_d2h_t`, `D2HRspIntgWidth`=7, `DataIntgWidth`=7, `D2HRspMaxWidth`=57, `DataMaxWidth`=32 and an `extract_d2h_rsp_intg` helper. The block adds no new package content.
- Natural sub-module: `tlul_rsp_intg_chk_core`, the combinational dual decoder producing `rsp_err`/`data_err`.
- The buffer is inline: 2 entries, a write pointer and an occupancy count.

Test Plan:
- Reset then AccessAckData, `d_data`=32'h1234_5678, correct integrity, `d_ready_i`=1 → `tl_o` shows the beat bit-exact next cycle; `intg_err_o`=0; `err_cnt_o`=0.
- Flip `d_data` bit 0 of one beat → `intg_err_pulse_o` high for exactly 1 cycle; `intg_err_o`=1 sticky; `err_cnt_o`=1. With FAILCLOSED: emitted `d_error`=1.
- Flip `rsp_intg` bit 6 with `CheckData`=0 and corrupt `d_data` on another beat → exactly one error counted, from the `rsp_intg` beat.
- Hold `d_ready_i`=0 and present 3 back-to-back valid beats → `d_ready_o` drops after the 2nd accept; release → beats emerge in order with no loss.
- 300 consecutive corrupted beats with `ErrCntW`=8 → `err_cnt_o` holds at 8'hFF without wrapping.
- Assert `rst_ni` low mid-stream with 2 beats buffered → `tl_o.d_valid`=0 immediately (asynchronous); after release `d_ready_o`=1, counters are 0 and `intg_err_o`=0.
